vcve2_vrf_seq: RTL
==================

// Module: vcve2_vrf_seq
// PURPOSE
// Sequencer for the memory-backed vector register file (VRF) of the vector-extended core. Per vector
// arithmetic instruction it walks the active element words: fetches vs2/vs1 words over a single data
// bus, presents operands to the vector ALU, writes the result word to vd. One bus transaction at a time.
// PARAMETERS
// VLEN     128   vector register length in bits; multiple of 32; VLENB = VLEN/8
// VRF_BASE 32'h0 byte address of v0; vN starts at VRF_BASE + N*VLENB (groups are contiguous)
// PORTS
// clk_i         in  1   clock
// rst_i         in  1   synchronous reset, active-high
// start_i       in  1   launch operation; sampled only in VRF_IDLE
// vs1_i/vs2_i/vd_i in 5 each  register indices, captured on accepted start
// vop_a_sel_i   in  2   vop_a_sel_e: VOP_A_VREG_A reads vs1; VOP_A_REG_A/VOP_A_IMM use scalar_i
// scalar_i      in  32  scalar/immediate operand A
// vl_i          in  $clog2(VLEN)+1  element count
// vsew_i        in  3   vsew_e element width
// busy_o        out 1   state != VRF_IDLE
// done_o        out 1   one-cycle pulse on return to VRF_IDLE
// illegal_o     out 1   one-cycle pulse with done_o when the request was rejected
// data_req_o/data_we_o out 1  bus request / write enable
// data_addr_o   out 32  word-aligned byte address
// data_wdata_o  out 32  = alu_result_i during writes
// data_be_o     out 4   byte enables
// data_gnt_i/data_rvalid_i in 1  grant / response valid (reads and writes)
// data_rdata_i  in  32  read data
// alu_op_a_o/alu_op_b_o out 32  registered operand words; alu_vsew_o out 3 captured vsew
// alu_result_i  in  32  combinational ALU result for current operands
// BEHAVIOUR
// - Reset: state VRF_IDLE; all outputs, word index, operand registers 0. Reset mid-operation aborts at
//   next edge: req drops, no done_o; rvalid arriving in IDLE is ignored.
// - Bytes = vl << vsew; Words = ceil(Bytes/4); LastBE = 4'b1111 if Bytes%4==0 else (1<<(Bytes%4))-1.
// - Address = VRF_BASE + reg*VLENB + idx*4; idx counts 0..Words-1 (crosses into next reg for LMUL>1).
// - Bus: req/addr/we/be held stable until gnt (gnt may arrive same cycle as req); rvalid earliest the
//   cycle after gnt; exactly one outstanding transaction.
// - FSM (vrf_state_t):
//   IDLE: start_i -> START (capture all inputs). start_i while busy ignored.
//   START: vsew not VSEW_8/16/32, or vl > VLEN*8/SEW -> IDLE, done_o+illegal_o, no bus traffic.
//          Words==0 -> IDLE with done_o. Else idx=0 -> READ1.
//   READ1: req read vs2 word; gnt -> WAITBUS (tag=B).
//   READ2: req read vs1 word; gnt -> WAITBUS (tag=A).
//   WRITE: req write vd word, be = (idx==Words-1) ? LastBE : 4'hF; gnt -> WAITBUS (tag=W).
//   WAITBUS on rvalid: tag B -> alu_op_b_o<=rdata; READ2 if VOP_A_VREG_A else WRITE.
//                      tag A -> alu_op_a_o<=rdata; WRITE.
//                      tag W -> last word ? IDLE + done_o : idx++, READ1.
//   READ3: reserved, never entered; if reached -> IDLE, no done_o.
// - Scalar splat (non-VREG_A), loaded in START: SEW8 {4{s[7:0]}}, SEW16 {2{s[15:0]}}, SEW32 s.
// - Min latency/word (gnt same cycle, rvalid next): 6 cycles with vs1, 4 without; +1 START, +0 exit.
// TESTING (VLEN=128, VRF_BASE=32'h1000)
// - vl=4 SEW32 VREG_A vs2=2 vs1=3 vd=1, zero-wait -> read 0x1020,0x1030, write 0x1010 be=F; 4 words;
//   addr+4 per word; done_o 25 cycles after start.
// - vl=5 SEW8 -> 2 words; second write addr 0x1014 be=4'b0001; done_o once.
// - VOP_A_REG_A scalar=32'h0000_00AB SEW8 -> alu_op_a_o=32'hABAB_ABAB, no vs1 reads ever issued.
// - vl=0 -> done_o cycle after START, no req; vsew=3'b111 -> done_o+illegal_o, no req.
// - vl=64 SEW16 vs2=8 (LMUL8 span) -> 32 words, reads 0x1080..0x10FC contiguous; vl=65 -> illegal.
// - gnt delayed 3 cycles: req/addr/be stable; rst_i in WAITBUS -> IDLE next cycle, busy_o=0,
//   later rvalid ignored; start_i during busy ignored.

Source files
------------

// File: rtl/vcve2_vrf_seq.sv
// vcve2_vrf_seq: per-instruction sequencer for the memory-backed vector
// register file. It walks the active element words of vs2 (and vs1 when
// operand A is a vector), hands the operand words to the vector ALU and
// writes the ALU result to vd, with one bus transaction in flight at a time.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 launch request, accepted only when idle
//   vs1_i/vs2_i/vd_i        register indices captured on an accepted start
//   vop_a_sel_i, scalar_i   operand A source select and scalar/immediate value
//   vl_i, vsew_i            element count and element width
//   busy_o/done_o/illegal_o status; done_o/illegal_o are one-cycle pulses
//   data_*                  single-outstanding data bus (req/gnt/rvalid)
//   alu_op_a_o/alu_op_b_o   registered operand words, alu_vsew_o captured vsew
//   alu_result_i            combinational ALU result for the current operands
module vcve2_vrf_seq #(
  parameter int unsigned VLEN     = 128,
  parameter logic [31:0] VRF_BASE = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [4:0]              vs1_i,
  input  logic [4:0]              vs2_i,
  input  logic [4:0]              vd_i,
  input  logic [1:0]              vop_a_sel_i,
  input  logic [31:0]             scalar_i,
  input  logic [$clog2(VLEN):0]   vl_i,
  input  logic [2:0]              vsew_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    illegal_o,
  output logic                    data_req_o,
  output logic                    data_we_o,
  output logic [31:0]             data_addr_o,
  output logic [31:0]             data_wdata_o,
  output logic [3:0]              data_be_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [31:0]             data_rdata_i,
  output logic [31:0]             alu_op_a_o,
  output logic [31:0]             alu_op_b_o,
  output logic [2:0]              alu_vsew_o,
  input  logic [31:0]             alu_result_i
);

  localparam int unsigned VLW   = $clog2(VLEN) + 1;
  localparam int unsigned VLENB = VLEN / 8;
  localparam int unsigned BW    = VLW + 2;  // byte count width (vl << 2 max)
  localparam int unsigned WW    = BW - 1;   // word count / index width

  typedef enum logic [2:0] {
    VRF_IDLE, VRF_START, VRF_READ1, VRF_READ2, VRF_READ3, VRF_WRITE, VRF_WAITBUS
  } vrf_state_t;

  typedef enum logic [1:0] {TAG_A, TAG_B, TAG_W} bus_tag_t;

  typedef enum logic [1:0] {
    VOP_A_VREG_A = 2'd0, VOP_A_REG_A = 2'd1, VOP_A_IMM = 2'd2
  } vop_a_sel_e;

  typedef enum logic [2:0] {VSEW_8 = 3'd0, VSEW_16 = 3'd1, VSEW_32 = 3'd2} vsew_e;

  vrf_state_t       state_q, state_d;
  bus_tag_t         tag_q, tag_d;
  logic [WW-1:0]    idx_q, idx_d;
  logic [4:0]       vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic             use_vs1_q, use_vs1_d;
  logic [31:0]      scalar_q, scalar_d;
  logic [VLW-1:0]   vl_q, vl_d;
  logic [2:0]       vsew_q, vsew_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic             done_q, done_d, illegal_q, illegal_d;

  logic [BW-1:0]    bytes;
  logic [WW-1:0]    words;
  logic [3:0]       last_be;
  logic             req_illegal;
  logic             last_word;
  logic [31:0]      splat;
  logic [4:0]       addr_reg;

  // Operation geometry from the captured request.
  always_comb begin
    bytes       = '0;
    splat       = scalar_q;
    req_illegal = 1'b0;
    case (vsew_q)
      VSEW_8:  begin bytes = BW'(vl_q);      splat = {4{scalar_q[7:0]}};  end
      VSEW_16: begin bytes = BW'(vl_q) << 1; splat = {2{scalar_q[15:0]}}; end
      VSEW_32: begin bytes = BW'(vl_q) << 2; splat = scalar_q;            end
      default: req_illegal = 1'b1;
    endcase
    // vl > VLEN*8/SEW is the same as the byte span exceeding an LMUL=8 group.
    if (32'(bytes) > VLEN) req_illegal = 1'b1;
    words = WW'((bytes + BW'(3)) >> 2);
    case (bytes[1:0])
      2'd1:    last_be = 4'b0001;
      2'd2:    last_be = 4'b0011;
      2'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
    last_word = (idx_q == words - WW'(1));
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    vd_d         = vd_q;
    use_vs1_d    = use_vs1_q;
    scalar_d     = scalar_q;
    vl_d         = vl_q;
    vsew_d       = vsew_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    addr_reg     = vs2_q;

    case (state_q)
      VRF_IDLE: begin
        if (start_i) begin
          vs1_d     = vs1_i;
          vs2_d     = vs2_i;
          vd_d      = vd_i;
          use_vs1_d = (vop_a_sel_i == VOP_A_VREG_A);
          scalar_d  = scalar_i;
          vl_d      = vl_i;
          vsew_d    = vsew_i;
          state_d   = VRF_START;
        end
      end
      VRF_START: begin
        if (req_illegal) begin
          state_d   = VRF_IDLE;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else if (words == '0) begin
          state_d = VRF_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = '0;
          state_d = VRF_READ1;
          if (!use_vs1_q) op_a_d = splat;
        end
      end
      VRF_READ1: begin
        data_req_o = 1'b1;
        data_be_o  = 4'hF;
        addr_reg   = vs2_q;
        if (data_gnt_i) begin
          tag_d   = TAG_B;
          state_d = VRF_WAITBUS;
        end
      end
      VRF_READ2: begin
        data_req_o = 1'b1;
        data_be_o  = 4'hF;
        addr_reg   = vs1_q;
        if (data_gnt_i) begin
          tag_d   = TAG_A;
          state_d = VRF_WAITBUS;
        end
      end
      VRF_WRITE: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_be_o    = last_word ? last_be : 4'hF;
        data_wdata_o = alu_result_i;
        addr_reg     = vd_q;
        if (data_gnt_i) begin
          tag_d   = TAG_W;
          state_d = VRF_WAITBUS;
        end
      end
      VRF_WAITBUS: begin
        if (data_rvalid_i) begin
          case (tag_q)
            TAG_B: begin
              op_b_d  = data_rdata_i;
              state_d = use_vs1_q ? VRF_READ2 : VRF_WRITE;
            end
            TAG_A: begin
              op_a_d  = data_rdata_i;
              state_d = VRF_WRITE;
            end
            default: begin
              if (last_word) begin
                state_d = VRF_IDLE;
                done_d  = 1'b1;
              end else begin
                idx_d   = idx_q + WW'(1);
                state_d = VRF_READ1;
              end
            end
          endcase
        end
      end
      // VRF_READ3 is reserved; any unexpected state drops back to idle silently.
      default: state_d = VRF_IDLE;
    endcase

    // Element words of a group are contiguous, so the index may run past VLENB.
    data_addr_o = data_req_o
                ? (VRF_BASE + 32'(addr_reg) * 32'(VLENB) + (32'(idx_q) << 2))
                : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= VRF_IDLE;
      tag_q     <= TAG_A;
      idx_q     <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      use_vs1_q <= 1'b0;
      scalar_q  <= '0;
      vl_q      <= '0;
      vsew_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      idx_q     <= idx_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vd_q      <= vd_d;
      use_vs1_q <= use_vs1_d;
      scalar_q  <= scalar_d;
      vl_q      <= vl_d;
      vsew_q    <= vsew_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy_o     = (state_q != VRF_IDLE);
  assign done_o     = done_q;
  assign illegal_o  = illegal_q;
  assign alu_op_a_o = op_a_q;
  assign alu_op_b_o = op_b_q;
  assign alu_vsew_o = vsew_q;

endmodule
